// File: rtl/cic_pkg.sv
// Shared definitions for the CIC decimation path: FSM state encoding,
// width derivation helpers and order clamping.
package cic_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACC,
    OUT
  } cic_state_e;

  function automatic int calc_ch_w(input int num_ch);
    return (num_ch <= 1) ? 1 : $clog2(num_ch);
  endfunction

  function automatic int calc_ord_w(input int num_stages);
    return $clog2(num_stages + 1);
  endfunction

  localparam int DEF_NUM_CH     = 4;
  localparam int DEF_NUM_STAGES = 5;
  localparam int DEF_CH_W       = calc_ch_w(DEF_NUM_CH);
  localparam int DEF_ORD_W      = calc_ord_w(DEF_NUM_STAGES);

  // Order 0 runs as a first-order integrator; anything above the built
  // stage count is limited to the deepest available stage.
  function automatic int clamp_order(input int order, input int num_stages);
    if (order == 0) return 1;
    if (order > num_stages) return num_stages;
    return order;
  endfunction

endpackage

// File: rtl/cic_acc_bank.sv
// Accumulator register file for all channels and integrator stages:
// one combinational read port, one write port, global synchronous clear.
module cic_acc_bank
  import cic_pkg::*;
#(
  parameter  int WIDTH      = 64,
  parameter  int NUM_CH     = DEF_NUM_CH,
  parameter  int NUM_STAGES = DEF_NUM_STAGES,
  localparam int CH_W       = calc_ch_w(NUM_CH),
  localparam int ST_W       = calc_ord_w(NUM_STAGES)
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             clr_i,
  input  logic             we_i,
  input  logic [CH_W-1:0]  wr_ch_i,
  input  logic [ST_W-1:0]  wr_stage_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic [CH_W-1:0]  rd_ch_i,
  input  logic [ST_W-1:0]  rd_stage_i,
  output logic [WIDTH-1:0] rd_data_o
);

  logic [WIDTH-1:0] r_acc [NUM_CH][NUM_STAGES];

  // NOTE: this bank is a flop array, not a RAM macro, so every entry takes the
  // async reset and the clear; a RAM-backed bank could do neither.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int c = 0; c < NUM_CH; c++)
        for (int s = 0; s < NUM_STAGES; s++)
          r_acc[c][s] <= '0;
    end else if (clr_i) begin
      for (int c = 0; c < NUM_CH; c++)
        for (int s = 0; s < NUM_STAGES; s++)
          r_acc[c][s] <= '0;
    end else if (we_i) begin
      r_acc[wr_ch_i][wr_stage_i] <= wr_data_i;
    end
  end

  assign rd_data_o = r_acc[rd_ch_i][rd_stage_i];

endmodule

// File: rtl/cic_integrator_mc.sv
// Time-multiplexed multi-channel CIC integrator: one shared adder walks a
// sample through its channel's integrator cascade, one stage per cycle.
module cic_integrator_mc
  import cic_pkg::*;
#(
  parameter  int WIDTH      = 64,
  parameter  int IN_WIDTH   = 16,
  parameter  int NUM_CH     = DEF_NUM_CH,
  parameter  int NUM_STAGES = DEF_NUM_STAGES,
  localparam int CH_W       = calc_ch_w(NUM_CH),
  localparam int ORD_W      = calc_ord_w(NUM_STAGES)
) (
  input  logic                clk_i,
  input  logic                rstn_i,
  input  logic                clr_i,
  input  logic [ORD_W-1:0]    order_i,
  input  logic                in_valid_i,
  output logic                in_ready_o,
  input  logic [CH_W-1:0]     in_ch_i,
  input  logic [IN_WIDTH-1:0] data_i,
  output logic                out_valid_o,
  input  logic                out_ready_i,
  output logic [CH_W-1:0]     out_ch_o,
  output logic [WIDTH-1:0]    data_o,
  output logic                busy_o
);

  cic_state_e       r_state;
  logic [WIDTH-1:0] r_carry;
  logic [CH_W-1:0]  r_ch;
  logic [ORD_W-1:0] r_order;
  logic [ORD_W-1:0] r_stage;

  logic [WIDTH-1:0] w_rd_data;
  logic [WIDTH-1:0] w_sum;
  logic             w_we;
  logic             w_ch_ok;
  logic             w_last_stage;

  assign w_sum        = w_rd_data + r_carry;
  assign w_we         = (r_state == ACC) && !clr_i;
  assign w_ch_ok      = int'(in_ch_i) < NUM_CH;
  assign w_last_stage = (r_stage == r_order - ORD_W'(1));

  cic_acc_bank #(
    .WIDTH      (WIDTH),
    .NUM_CH     (NUM_CH),
    .NUM_STAGES (NUM_STAGES)
  ) u_bank (
    .clk_i      (clk_i),
    .rstn_i     (rstn_i),
    .clr_i      (clr_i),
    .we_i       (w_we),
    .wr_ch_i    (r_ch),
    .wr_stage_i (r_stage),
    .wr_data_i  (w_sum),
    .rd_ch_i    (r_ch),
    .rd_stage_i (r_stage),
    .rd_data_o  (w_rd_data)
  );

  // NOTE: all state lives in one clocked block with non-blocking assignments,
  // so every register samples the pre-edge values of its neighbours.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_state <= IDLE;
      r_carry <= '0;
      r_ch    <= '0;
      r_order <= ORD_W'(1);
      r_stage <= '0;
    end else if (clr_i) begin
      r_state <= IDLE;
      r_carry <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          // Samples for a nonexistent channel are swallowed without leaving IDLE.
          if (in_valid_i && w_ch_ok) begin
            r_carry <= WIDTH'($signed(data_i));
            r_ch    <= in_ch_i;
            r_order <= ORD_W'(clamp_order(int'(order_i), NUM_STAGES));
            r_stage <= '0;
            r_state <= ACC;
          end
        end
        ACC: begin
          r_carry <= w_sum;
          r_stage <= r_stage + ORD_W'(1);
          if (w_last_stage) r_state <= OUT;
        end
        OUT: begin
          if (out_ready_i) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready_o  = (r_state == IDLE) && !clr_i;
  assign out_valid_o = (r_state == OUT);
  assign out_ch_o    = r_ch;
  assign data_o      = r_carry;
  assign busy_o      = (r_state != IDLE);

endmodule

// File: doc/cic_integrator_mc.md
# cic_integrator_mc

Time-multiplexed, multi-channel, multi-stage CIC integrator section for the PDM/I2S decimation path. It sits between the PDM front-end and the decimating comb section. Each accepted input sample is tagged with a channel. The block runs that sample through up to NUM_STAGES cascaded integrators using a single shared adder, one stage per cycle. It then presents the last active stage's new value on a valid/ready output.

## Interface
- WIDTH, 64: accumulator and output width.
- IN_WIDTH, 16: signed input sample width; must satisfy IN_WIDTH ≤ WIDTH.
- NUM_CH, 4: number of channels, ≥1.
- NUM_STAGES, 5: maximum integrator order, ≥1.
- Derived: CH_W = max(1, $clog2(NUM_CH)); ORD_W = $clog2(NUM_STAGES+1).
- clk_i  in  1  clock.
- rstn_i  in  1  reset, asynchronous, active-low.
- clr_i  in  1  synchronous clear: zeroes all accumulators and aborts any in-flight sample.
- order_i  in  ORD_W  active integrator order; sampled at input handshake.
- in_valid_i  in  1  input sample valid.
- in_ready_o  out  1  block accepts a sample.
- in_ch_i  in  CH_W  channel of input sample.
- data_i  in  IN_WIDTH  signed input sample.
- out_valid_o  out  1  output valid.
- out_ready_i  in  1  downstream accepts output.
- out_ch_o  out  CH_W  channel of output.
- data_o  out  WIDTH  integrated value.
- busy_o  out  1  state ≠ IDLE.

## Operation
- Storage: acc[NUM_CH][NUM_STAGES], each WIDTH bits.
- Pipeline registers: carry (WIDTH), channel (CH_W), order (ORD_W), stage counter.
- FSM states: IDLE, ACC, OUT.
- IDLE:
  - in_ready_o = 1 unless clr_i.
  - On in_valid_i & in_ready_o: capture the channel, and capture carry = data_i sign-extended to WIDTH.
  - Capture order: order_i = 0 is treated as 1; order_i > NUM_STAGES is clamped to NUM_STAGES.
  - Set stage = 0 and go to ACC.
- ACC, one stage per cycle:
  - sum = acc[ch][stage] + carry, computed mod 2^WIDTH (wrap-around is intended CIC behaviour; no saturation).
  - acc[ch][stage] ← sum; carry ← sum; stage++.
  - After stage order−1 is written, go to OUT.
  - Stages ≥ order are untouched.
- OUT:
  - out_valid_o = 1; data_o = carry; out_ch_o = channel.
  - Outputs hold stable while out_ready_i = 0.
  - On out_valid_o & out_ready_i, go to IDLE.
- Invalid channel (in_ch_i ≥ NUM_CH): the sample is accepted, no accumulator is modified, no output is produced, and the FSM returns to IDLE the next cycle.
- clr_i has highest priority, in any state:
  - All acc entries and carry are set to 0, and the FSM goes to IDLE.
  - out_valid_o is deasserted the next cycle.
  - in_ready_o = 0 during the clr_i cycle.
  - An in-flight output is dropped.
- Reset values:
  - acc, carry, channel, stage = 0; order = 1.
  - State = IDLE; in_ready_o = 1 after reset release.
  - out_valid_o = 0; data_o = 0; out_ch_o = 0; busy_o = 0.
- Channels are fully independent; the accumulator state of one channel is never read while processing another.

## Timing
- Input handshake in cycle T.
- Stage k is written at the clock edge ending cycle T+1+k.
- out_valid_o is high from cycle T+order+1.
- With out_ready_i held 1, the output transfer occurs in cycle T+order+1, and the next sample can be accepted in cycle T+order+2.
- Minimum throughput: one sample per order+2 cycles.
- in_ready_o is a registered-state decode combined combinationally with clr_i only; no input-to-output combinational path.
- order_i changes after the handshake do not affect the in-flight sample.
- Reset asserted mid-operation: all state returns to reset values immediately, asynchronously.

## Structure
- Shared package cic_pkg:
  - cic_state_e enum {IDLE, ACC, OUT}.
  - Function clamp_order().
  - Localparams for CH_W and ORD_W derivation, reused by the comb block.
- Sub-module cic_acc_bank: the NUM_CH×NUM_STAGES accumulator register file.
  - One read port and one write port, addressed by (ch, stage).
  - Synchronous global clear.
  - Asynchronous reset to zero.
- The FSM, shared adder and handshake logic stay in the top module.

## Test plan
- Reset, then idle: in_ready_o=1, out_valid_o=0, data_o=0, busy_o=0.
- Impulse, ch0, order_i=3: inputs 1,0,0,0 produce outputs 1,3,6,10 on ch0; each out_valid_o rises 4 cycles after its handshake.
- Channel isolation, order_i=1: alternate ch1 ← 5 and ch2 ← −2, three times each. Outputs are ch1: 5,10,15 and ch2: −2,−4,−6; ch0 and ch3 accumulators remain 0.
- Wrap: WIDTH=8, IN_WIDTH=8, order 1, inputs 100,100 give outputs 100, then 0xC8 (−56).
- Back-pressure: hold out_ready_i=0 for 10 cycles in OUT. data_o and out_ch_o stay stable, in_ready_o=0, and a single transfer occurs when out_ready_i rises.
- clr_i asserted during ACC of an order-5 sample: no output is produced, and the next impulse 1 at order 1 outputs 1.
- Separately, in_ch_i=NUM_CH is accepted, produces no output, and leaves accumulators unchanged.
